bank_cmd_arbiter: RTL and testbench
===================================

Name: bank_cmd_arbiter

Overview:
- Sits between NBANKS bank machines and the PHY command port. Each cycle it selects at most one bank command by round-robin.
- Enforces the inter-bank timings a single bank machine cannot see: tRRD between ACTIVATEs, tCCD between column commands, and tWTR from write to read.
- Produces one registered command per cycle, with the bank address equal to the granted bank index.

Parameters:
- NBANKS, 8, number of bank machines; power of two, 2..16.
- BABITS, 3, log2(NBANKS).
- ABITS, 14, command address width.
- TRRD, 2, minimum cycles between ACT grants; 0 or 1 means no restriction.
- TCCD, 1, minimum cycles between CAS grants; 0 or 1 means no restriction.
- TWTR, 4, minimum cycles from a write grant to a read grant; 0 or 1 means no restriction.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous reset, active low.
- enable  in  1  grants are allowed only while high; used by refresh/init sequencing.
- bm_valid  in  NBANKS  per-bank command valid.
- bm_ready  out  NBANKS  per-bank accept; one-hot or zero.
- bm_a  in  NBANKS*ABITS  per-bank address; bank i occupies bits [i*ABITS +: ABITS].
- bm_cas, bm_ras, bm_we  in  NBANKS each  per-bank command bits.
- bm_is_cmd, bm_is_read, bm_is_write  in  NBANKS each  per-bank command class.
- out_valid  out  1  registered command strobe.
- out_a  out  ABITS  registered address.
- out_ba  out  BABITS  registered bank index.
- out_cas, out_ras, out_we  out  1 each  registered command bits.
- out_is_read, out_is_write  out  1 each  registered command class.

Behaviour:
- Reset (async assert, sync release): all out_* = 0, all timers = 0, round-robin pointer last = NBANKS-1, so bank 0 has priority first.

Command classification per bank i:
- ACT = is_cmd & ras & ~cas & ~we.
- CAS = cas (is_read or is_write).
- RD = is_read.
- Anything else (PRE, etc.) is not timing-checked here.

Eligibility:
- elig[i] = enable & bm_valid[i] & ~(ACT & trrd_cnt != 0) & ~(CAS & tccd_cnt != 0) & ~(RD & twtr_cnt != 0).

Grant:
- g = first i with elig[i], scanning (last+1) mod NBANKS upward with wrap.
- bm_ready[g] = 1 combinationally in the same cycle; all other bm_ready bits = 0.
- With no eligible bank, bm_ready = 0.
- bm_ready never asserts for a bank whose bm_valid is low.

Pointer:
- On a grant, last <= g. With no grant, last holds.
- A continuously requesting bank therefore waits at most NBANKS-1 grants.

Output register:
- Latency 1. On a grant, next cycle: out_valid = 1, out_ba = g, and the other out_* fields copy bank g's fields.
- Otherwise out_valid = 0 and all other out_* = 0 (no stale command bits).

Timers (3 bits wide, or wider if a parameter needs it; all saturate at 0):
- ACT grant: trrd_cnt <= max(TRRD-1, 0).
- CAS grant: tccd_cnt <= max(TCCD-1, 0).
- Write grant: twtr_cnt <= max(TWTR-1, 0).
- A timer that is not loaded decrements if nonzero.
- Net effect: an ACT granted at cycle t allows the next ACT no earlier than t+TRRD. The same rule applies to CAS with TCCD and to write-to-read with TWTR.
- A load and a decrement never coincide, because the loaded timer is by definition the one whose class was granted.

enable low:
- No grants. Timers keep decrementing. Pointer holds.
- Commands issued before enable fell still appear on out_* one cycle later.

Bank machine responsibility:
- Requests remain valid and stable until accepted.
- The arbiter never drops a request and never issues one twice.

Reset mid-operation:
- Any pending output is cleared and timers zeroed immediately.
- Requests still held valid when reset releases are re-arbitrated from bank 0.

Test Plan:
- Single request: bank 3 requests a read with a=0x0123 -> bm_ready=0b00001000 in the same cycle; next cycle out_valid=1, out_ba=3, out_a=0x0123, out_is_read=1.
- Fairness: all 8 banks request continuously with PRE commands -> grants in order 0,1,...,7,0 with no skipped cycles.
- tRRD=2: banks 0 and 1 both request ACT -> bank 0 granted at t, bank 1 granted at t+2; t+1 has no grant unless a non-ACT command is pending.
- tWTR=4: bank 2 write granted at t while bank 5 has a read pending -> bank 5 read granted at t+4. A bank 6 PRE pending at t+1 is granted at t+1.
- enable: drop enable with 3 banks valid -> bm_ready=0 for the whole low period. Raising enable resumes at the pointer position.
- Async reset: assert sys_rst_n=0 mid-stream with out_valid=1 -> out_valid=0 immediately, without a clock edge. After release, the first grant goes to the lowest valid bank.

Source files
------------

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter from NBANKS bank machines onto a single registered PHY
// command slot, enforcing the inter-bank tRRD / tCCD / tWTR spacing.

module bank_cmd_elig #(
  parameter int TW = 3
) (
  input  logic          enable_i,
  input  logic          valid_i,
  input  logic          is_cmd_i,
  input  logic          ras_i,
  input  logic          cas_i,
  input  logic          we_i,
  input  logic          is_read_i,
  input  logic          is_write_i,
  input  logic [TW-1:0] trrd_i,
  input  logic [TW-1:0] tccd_i,
  input  logic [TW-1:0] twtr_i,
  output logic          is_act_o,
  output logic          is_cas_o,
  output logic          elig_o
);
  assign is_act_o = is_cmd_i & ras_i & ~cas_i & ~we_i;
  assign is_cas_o = cas_i & (is_read_i | is_write_i);
  assign elig_o   = enable_i & valid_i
                  & ~(is_act_o  & (trrd_i != '0))
                  & ~(is_cas_o  & (tccd_i != '0))
                  & ~(is_read_i & (twtr_i != '0));
endmodule

module bank_cmd_arbiter #(
  parameter int NBANKS = 8,
  parameter int BABITS = 3,
  parameter int ABITS  = 14,
  parameter int TRRD   = 2,
  parameter int TCCD   = 1,
  parameter int TWTR   = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    enable,
  input  logic [NBANKS-1:0]       bm_valid,
  output logic [NBANKS-1:0]       bm_ready,
  input  logic [NBANKS*ABITS-1:0] bm_a,
  input  logic [NBANKS-1:0]       bm_cas,
  input  logic [NBANKS-1:0]       bm_ras,
  input  logic [NBANKS-1:0]       bm_we,
  input  logic [NBANKS-1:0]       bm_is_cmd,
  input  logic [NBANKS-1:0]       bm_is_read,
  input  logic [NBANKS-1:0]       bm_is_write,
  output logic                    out_valid,
  output logic [ABITS-1:0]        out_a,
  output logic [BABITS-1:0]       out_ba,
  output logic                    out_cas,
  output logic                    out_ras,
  output logic                    out_we,
  output logic                    out_is_read,
  output logic                    out_is_write
);
  localparam int TMAX = (TRRD > TCCD) ? ((TRRD > TWTR) ? TRRD : TWTR)
                                      : ((TCCD > TWTR) ? TCCD : TWTR);
  localparam int TW = (TMAX > 8) ? $clog2(TMAX) : 3;
  localparam logic [TW-1:0] TRRD_LD = (TRRD > 1) ? TW'(TRRD - 1) : '0;
  localparam logic [TW-1:0] TCCD_LD = (TCCD > 1) ? TW'(TCCD - 1) : '0;
  localparam logic [TW-1:0] TWTR_LD = (TWTR > 1) ? TW'(TWTR - 1) : '0;

  logic [TW-1:0]     trrd_q, trrd_d, tccd_q, tccd_d, twtr_q, twtr_d;
  logic [BABITS-1:0] last_q, last_d;
  logic [NBANKS-1:0] elig, is_act, is_cas;

  logic              gnt;
  logic [BABITS-1:0] gnt_idx;

  logic              out_valid_q, out_cas_q, out_ras_q, out_we_q;
  logic              out_is_read_q, out_is_write_q;
  logic [ABITS-1:0]  out_a_q;
  logic [BABITS-1:0] out_ba_q;

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    bank_cmd_elig #(.TW(TW)) u_elig (
      .enable_i   (enable),
      .valid_i    (bm_valid[i]),
      .is_cmd_i   (bm_is_cmd[i]),
      .ras_i      (bm_ras[i]),
      .cas_i      (bm_cas[i]),
      .we_i       (bm_we[i]),
      .is_read_i  (bm_is_read[i]),
      .is_write_i (bm_is_write[i]),
      .trrd_i     (trrd_q),
      .tccd_i     (tccd_q),
      .twtr_i     (twtr_q),
      .is_act_o   (is_act[i]),
      .is_cas_o   (is_cas[i]),
      .elig_o     (elig[i])
    );
  end

  // Scan last+1 .. last+NBANKS; BABITS-wide addition wraps since NBANKS is 2^BABITS.
  always_comb begin
    logic [BABITS-1:0] idx;
    idx      = '0;
    gnt      = 1'b0;
    gnt_idx  = '0;
    bm_ready = '0;
    for (int k = 1; k <= NBANKS; k++) begin
      idx = last_q + BABITS'(k);
      if (!gnt && elig[idx]) begin
        gnt     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (gnt) bm_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    last_d = gnt ? gnt_idx : last_q;
    trrd_d = (trrd_q != '0) ? trrd_q - 1'b1 : '0;
    tccd_d = (tccd_q != '0) ? tccd_q - 1'b1 : '0;
    twtr_d = (twtr_q != '0) ? twtr_q - 1'b1 : '0;
    if (gnt && is_act[gnt_idx])         trrd_d = TRRD_LD;
    if (gnt && is_cas[gnt_idx])         tccd_d = TCCD_LD;
    if (gnt && bm_is_write[gnt_idx])    twtr_d = TWTR_LD;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_q         <= BABITS'(NBANKS - 1);
      trrd_q         <= '0;
      tccd_q         <= '0;
      twtr_q         <= '0;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_ba_q       <= '0;
      out_cas_q      <= 1'b0;
      out_ras_q      <= 1'b0;
      out_we_q       <= 1'b0;
      out_is_read_q  <= 1'b0;
      out_is_write_q <= 1'b0;
    end else begin
      last_q         <= last_d;
      trrd_q         <= trrd_d;
      tccd_q         <= tccd_d;
      twtr_q         <= twtr_d;
      // Idle cycles drive zeros so the PHY never sees stale command bits.
      out_valid_q    <= gnt;
      out_a_q        <= gnt ? bm_a[gnt_idx*ABITS +: ABITS] : '0;
      out_ba_q       <= gnt ? gnt_idx : '0;
      out_cas_q      <= gnt & bm_cas[gnt_idx];
      out_ras_q      <= gnt & bm_ras[gnt_idx];
      out_we_q       <= gnt & bm_we[gnt_idx];
      out_is_read_q  <= gnt & bm_is_read[gnt_idx];
      out_is_write_q <= gnt & bm_is_write[gnt_idx];
    end
  end

  assign out_valid    = out_valid_q;
  assign out_a        = out_a_q;
  assign out_ba       = out_ba_q;
  assign out_cas      = out_cas_q;
  assign out_ras      = out_ras_q;
  assign out_we       = out_we_q;
  assign out_is_read  = out_is_read_q;
  assign out_is_write = out_is_write_q;
endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Directed bench for bank_cmd_arbiter: grants, round-robin order, timing gaps,
// enable gating and asynchronous reset, all with hand-computed expectations.

module tb_bank_cmd_arbiter;
  localparam int NB = 8;
  localparam int AB = 14;
  localparam int K_RD = 0, K_WR = 1, K_ACT = 2, K_PRE = 3;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic           enable;
  logic [NB-1:0]  bm_valid, bm_ready, bm_cas, bm_ras, bm_we;
  logic [NB-1:0]  bm_is_cmd, bm_is_read, bm_is_write;
  logic [NB*AB-1:0] bm_a;
  logic           out_valid, out_cas, out_ras, out_we, out_is_read, out_is_write;
  logic [AB-1:0]  out_a;
  logic [2:0]     out_ba;

  int n_chk  = 0;
  int n_pass = 0;

  bank_cmd_arbiter dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .bm_valid(bm_valid), .bm_ready(bm_ready), .bm_a(bm_a),
    .bm_cas(bm_cas), .bm_ras(bm_ras), .bm_we(bm_we),
    .bm_is_cmd(bm_is_cmd), .bm_is_read(bm_is_read), .bm_is_write(bm_is_write),
    .out_valid(out_valid), .out_a(out_a), .out_ba(out_ba),
    .out_cas(out_cas), .out_ras(out_ras), .out_we(out_we),
    .out_is_read(out_is_read), .out_is_write(out_is_write)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic req(input int b, input int kind, input logic [AB-1:0] a);
    bm_valid[b]    = 1'b1;
    bm_a[b*AB +: AB] = a;
    bm_is_cmd[b]   = 1'b1;
    bm_cas[b]      = (kind == K_RD) || (kind == K_WR);
    bm_ras[b]      = (kind == K_ACT) || (kind == K_PRE);
    bm_we[b]       = (kind == K_WR) || (kind == K_PRE);
    bm_is_read[b]  = (kind == K_RD);
    bm_is_write[b] = (kind == K_WR);
  endtask

  task automatic clr(input int b);
    bm_valid[b] = 1'b0; bm_a[b*AB +: AB] = '0; bm_is_cmd[b] = 1'b0;
    bm_cas[b] = 1'b0; bm_ras[b] = 1'b0; bm_we[b] = 1'b0;
    bm_is_read[b] = 1'b0; bm_is_write[b] = 1'b0;
  endtask

  task automatic pulse_reset();
    sys_rst_n = 1'b0;
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    enable = 1'b1;
    sys_rst_n = 1'b0;
    for (int b = 0; b < NB; b++) clr(b);
    repeat (2) @(negedge sys_clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ba", out_ba, 0);
    chk("rst_ready", bm_ready, 0);
    sys_rst_n = 1'b1;

    // single read on bank 3
    @(negedge sys_clk); req(3, K_RD, 14'h0123);
    #1 chk("single_ready", bm_ready, 8'h08);
    @(negedge sys_clk); clr(3);
    chk("single_valid", out_valid, 1);
    chk("single_ba", out_ba, 3);
    chk("single_a", out_a, 14'h0123);
    chk("single_is_read", out_is_read, 1);
    chk("single_cas", out_cas, 1);
    #1 chk("single_ready_off", bm_ready, 0);
    @(negedge sys_clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_a_zero", out_a, 0);
    chk("idle_is_read_zero", out_is_read, 0);

    // fairness: all banks PRE continuously, starting from bank 0 after reset
    pulse_reset();
    for (int b = 0; b < NB; b++) req(b, K_PRE, AB'(b * 'h111));
    for (int k = 0; k < 9; k++) begin
      #1 chk("rr_ready", bm_ready, 32'(1) << (k % NB));
      @(negedge sys_clk);
      chk("rr_out_ba", out_ba, k % NB);
      chk("rr_out_a", out_a, (k % NB) * 'h111);
    end
    for (int b = 0; b < NB; b++) clr(b);

    // tRRD = 2 between ACTs on banks 0 and 1
    pulse_reset();
    req(0, K_ACT, 14'h0010); req(1, K_ACT, 14'h0011);
    #1 chk("trrd_first", bm_ready, 8'h01);
    @(negedge sys_clk); clr(0);
    #1 chk("trrd_gap", bm_ready, 8'h00);
    @(negedge sys_clk);
    chk("trrd_gap_out", out_valid, 0);
    #1 chk("trrd_second", bm_ready, 8'h02);
    @(negedge sys_clk); clr(1);
    chk("trrd_second_ba", out_ba, 1);
    chk("trrd_second_ras", out_ras, 1);

    // tWTR = 4: write on 2, read on 5 waits, PRE on 6 slips in
    pulse_reset();
    req(2, K_WR, 14'h0aaa); req(5, K_RD, 14'h0555);
    #1 chk("twtr_write", bm_ready, 8'h04);
    @(negedge sys_clk); clr(2); req(6, K_PRE, 14'h0666);
    chk("twtr_write_out", out_is_write, 1);
    #1 chk("twtr_pre", bm_ready, 8'h40);
    @(negedge sys_clk); clr(6);
    chk("twtr_pre_ba", out_ba, 6);
    chk("twtr_pre_we", out_we, 1);
    #1 chk("twtr_t2", bm_ready, 8'h00);
    @(negedge sys_clk);
    #1 chk("twtr_t3", bm_ready, 8'h00);
    @(negedge sys_clk);
    #1 chk("twtr_read", bm_ready, 8'h20);
    @(negedge sys_clk); clr(5);
    chk("twtr_read_ba", out_ba, 5);
    chk("twtr_read_a", out_a, 14'h0555);
    chk("twtr_read_is_read", out_is_read, 1);

    // enable low blocks grants, pointer holds
    pulse_reset();
    req(1, K_PRE, 14'h0101); req(3, K_PRE, 14'h0303); req(5, K_PRE, 14'h0505);
    #1 chk("en_first", bm_ready, 8'h02);
    @(negedge sys_clk); clr(1); enable = 1'b0;
    chk("en_late_out", out_valid, 1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("en_low_ready", bm_ready, 0);
      @(negedge sys_clk);
      chk("en_low_out", out_valid, 0);
    end
    enable = 1'b1;
    #1 chk("en_resume", bm_ready, 8'h08);
    @(negedge sys_clk); clr(3); clr(5);
    chk("en_resume_ba", out_ba, 3);

    // async reset mid-stream
    req(4, K_RD, 14'h0444); req(6, K_PRE, 14'h0666);
    #1 chk("ar_grant", bm_ready, 8'h10);
    @(negedge sys_clk); clr(4);
    chk("ar_pre_valid", out_valid, 1);
    #2 sys_rst_n = 1'b0;
    #1 chk("ar_valid_cleared", out_valid, 0);
    chk("ar_a_cleared", out_a, 0);
    chk("ar_ba_cleared", out_ba, 0);
    req(2, K_PRE, 14'h0222);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    #1 chk("ar_lowest_first", bm_ready, 8'h04);
    @(negedge sys_clk); clr(2); clr(6);
    chk("ar_lowest_ba", out_ba, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
